i2c_txn_sequencer: RTL

- Sits between N transaction requesters (Wishbone-side command sources) and the single shared I2C byte-level engine.
- Grants the engine round-robin to one requester at a time.
- Sequences START, address+R/W, data bytes and STOP as individual byte-engine commands, collects responses and reports per-requester completion status.
- Includes a watchdog so that a stuck engine cannot hold the bus indefinitely.

---
 rtl/i2c_pkg.sv | 44 ++++
 rtl/i2c_rr_arbiter.sv | 61 ++++++
 rtl/i2c_txn_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_pkg
//  Purpose : Shared types for the I2C transaction sequencer: engine command
//            codes, per-transaction completion status, the READ/WRITE
//            operation type and the sequencer FSM state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [0:0] {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    TXN_OK       = 2'd0,
    TXN_NAK      = 2'd1,
    TXN_ARB_LOST = 2'd2,
    TXN_TIMEOUT  = 2'd3
  } i2c_txn_status_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_START  = 3'd2,
    S_ADDR   = 3'd3,
    S_WDATA  = 3'd4,
    S_RDATA  = 3'd5,
    S_STOP   = 3'd6,
    S_FINISH = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_rr_arbiter
//  Purpose : Round-robin selector. Combinationally picks the first asserted
//            request at or after the pointer (wrapping). On advance the
//            pointer moves to the slot after the finishing owner.
//  Ports   : clk, rst_n       clock / async active-low reset
//            req              request vector
//            advance          move pointer past owner_idx this cycle
//            owner_idx        index of the requester that just finished
//            grant            one-hot selection (zero if no request)
//            grant_idx        binary index of the selection
//            any_req          at least one request is pending
//  Rev     : 1.0  initial release
// ============================================================================
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   owner_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign any_req = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_txn_sequencer
//  Purpose : Shares one I2C byte engine among NUM_REQ requesters. Grants the
//            engine round-robin, issues START / address / data / STOP as
//            single engine commands, and reports completion status per
//            requester. A watchdog bounds the wait for every engine response.
//  Ports   : clk, rst_n                         clock / async active-low reset
//            req_i, addr_i, rw_i, len_i         per-requester transaction
//            wr_data_i / wr_pop_o               write byte stream handshake
//            rd_valid_o, rd_data_o              read byte stream
//            grant_o, done_o, status_o          ownership and completion
//            cmd_o, cmd_stb_o, cmd_wdata_o      engine command interface
//            rsp_done_i, rsp_nak_i, rsp_al_i,
//            rsp_rdata_i                        engine response interface
//  Rev     : 1.0  initial release
// ============================================================================
module i2c_txn_sequencer #(
  parameter int NUM_REQ        = 2,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]                rw_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      len_i,
  input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic                              wr_pop_o,
  output logic                              rd_valid_o,
  output logic [I2C_DATA_WIDTH-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [1:0]                        status_o,
  output logic [2:0]                        cmd_o,
  output logic                              cmd_stb_o,
  output logic [I2C_DATA_WIDTH-1:0]         cmd_wdata_o,
  input  logic                              rsp_done_i,
  input  logic                              rsp_nak_i,
  input  logic                              rsp_al_i,
  input  logic [I2C_DATA_WIDTH-1:0]         rsp_rdata_i
);

  import i2c_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t                state, state_n;
  logic                      issue, issue_n;     // first cycle of a command state
  logic [NUM_REQ-1:0]        grant, grant_n;
  logic [IDX_W-1:0]          owner, owner_n;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_n;
  i2c_op_t                   rw_q, rw_n;
  logic [LEN_WIDTH-1:0]      rem, rem_n;
  i2c_txn_status_t           status_q, status_n;
  logic [WD_W-1:0]           wd, wd_n;
  logic [I2C_DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                      rd_valid_q, rd_valid_n;
  logic [I2C_DATA_WIDTH-1:0] rd_data_q, rd_data_n;

  logic [NUM_REQ-1:0]        arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_any;
  logic [I2C_DATA_WIDTH-1:0] owner_wdata;
  i2c_cmd_t                  cmd_sel;

  i2c_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_i),
    .advance   (state == S_FINISH),
    .owner_idx (owner),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign owner_wdata = wr_data_i[int'(owner)*I2C_DATA_WIDTH +: I2C_DATA_WIDTH];

  always_comb begin
    state_n    = state;
    issue_n    = issue;
    grant_n    = grant;
    owner_n    = owner;
    addr_n     = addr_q;
    rw_n       = rw_q;
    rem_n      = rem;
    status_n   = status_q;
    wd_n       = wd;
    wdata_n    = wdata_q;
    rd_valid_n = 1'b0;
    rd_data_n  = rd_data_q;

    case (state)
      S_IDLE: begin
        if (arb_any) begin
          grant_n  = arb_grant;
          owner_n  = arb_idx;
          addr_n   = addr_i[int'(arb_idx)*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
          rw_n     = i2c_op_t'(rw_i[arb_idx]);
          rem_n    = len_i[int'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
          status_n = TXN_OK;
          state_n  = S_GRANT;
        end
      end
      S_GRANT: begin
        state_n = S_START;
        issue_n = 1'b1;
      end
      S_FINISH: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
      default: begin
        if (issue) begin
          // Strobe cycle. The watchdog counts cycles since the strobe, so it
          // starts at 1 for the first waiting cycle; the write byte is held
          // locally because the requester moves to its next byte after pop.
          issue_n = 1'b0;
          wd_n    = WD_W'(1);
          if (state == S_WDATA) wdata_n = owner_wdata;
        end else if (rsp_al_i) begin
          state_n  = S_FINISH;
          status_n = TXN_ARB_LOST;
        end else if (rsp_done_i) begin
          issue_n = 1'b1;
          case (state)
            S_START: state_n = S_ADDR;
            S_ADDR: begin
              if (rsp_nak_i) begin
                state_n  = S_STOP;
                status_n = TXN_NAK;
              end else if (rem == '0) begin
                state_n = S_STOP;
              end else if (rw_q == OP_READ) begin
                state_n = S_RDATA;
              end else begin
                state_n = S_WDATA;
              end
            end
            S_WDATA: begin
              rem_n = rem - LEN_WIDTH'(1);
              if (rsp_nak_i) begin
                state_n  = S_STOP;
                status_n = TXN_NAK;
              end else if (rem == LEN_WIDTH'(1)) begin
                state_n = S_STOP;
              end
            end
            S_RDATA: begin
              rd_valid_n = 1'b1;
              rd_data_n  = rsp_rdata_i;
              rem_n      = rem - LEN_WIDTH'(1);
              if (rem == LEN_WIDTH'(1)) state_n = S_STOP;
            end
            S_STOP: begin
              state_n = S_FINISH;
              issue_n = 1'b0;
            end
            default: issue_n = 1'b0;
          endcase
        end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Expiring here puts done_o exactly TIMEOUT_CYCLES after the strobe.
          state_n  = S_FINISH;
          status_n = TXN_TIMEOUT;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      issue      <= 1'b0;
      grant      <= '0;
      owner      <= '0;
      addr_q     <= '0;
      rw_q       <= OP_WRITE;
      rem        <= '0;
      status_q   <= TXN_OK;
      wd         <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state      <= state_n;
      issue      <= issue_n;
      grant      <= grant_n;
      owner      <= owner_n;
      addr_q     <= addr_n;
      rw_q       <= rw_n;
      rem        <= rem_n;
      status_q   <= status_n;
      wd         <= wd_n;
      wdata_q    <= wdata_n;
      rd_valid_q <= rd_valid_n;
      rd_data_q  <= rd_data_n;
    end
  end

  always_comb begin
    cmd_sel     = CMD_START;
    cmd_wdata_o = '0;
    case (state)
      S_ADDR: begin
        cmd_sel     = CMD_WRITE;
        cmd_wdata_o = I2C_DATA_WIDTH'({addr_q, rw_q});
      end
      S_WDATA: begin
        cmd_sel     = CMD_WRITE;
        cmd_wdata_o = issue ? owner_wdata : wdata_q;
      end
      S_RDATA: cmd_sel = (rem == LEN_WIDTH'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
      S_STOP:  cmd_sel = CMD_STOP;
      default: cmd_sel = CMD_START;
    endcase
  end

  assign cmd_o      = cmd_sel;
  assign cmd_stb_o  = issue;
  assign wr_pop_o   = issue && (state == S_WDATA);
  assign grant_o    = grant;
  assign done_o     = (state == S_FINISH) ? grant : '0;
  assign status_o   = (state == S_FINISH) ? status_q : TXN_OK;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire
